// File: rtl/vc_multi_credit_counter_pkg.sv
// Shared types and helpers for the multi-channel credit counter.
//   cr_outcome_e   : result class of one channel's net credit update
//   cr_classify    : maps a signed net credit value onto cr_outcome_e
//   cr_params_ok   : parameter legality check used at elaboration
package vc_multi_credit_counter_pkg;

   typedef enum logic [1:0] {
      CR_OK    = 2'd0,
      CR_UNDER = 2'd1,
      CR_OVER  = 2'd2
   } cr_outcome_e;

   function automatic cr_outcome_e cr_classify(input int net, input int max_credits);
      cr_outcome_e res;
      if (net < 0)
         res = CR_UNDER;
      else if (net > max_credits)
         res = CR_OVER;
      else
         res = CR_OK;
      return res;
   endfunction

   function automatic bit cr_params_ok(input int nchans, input int count_nbits,
                                       input int max_credits, input int init_credits);
      return (nchans >= 1) && (count_nbits >= 1) && (count_nbits < 31) &&
             (max_credits < (1 << count_nbits)) && (init_credits <= max_credits) &&
             (init_credits >= 0);
   endfunction

endpackage

// File: rtl/vc_multi_credit_counter_chan.sv
// Resettable register and one credit-counter channel.
//
// vc_ResetReg: plain register with synchronous active-high reset.
//   clk, reset : clock / sync reset
//   d, q       : data in / registered data out
//
// vc_credit_counter_chan: one saturating credit counter.
//   clear          : reload count with p_init_credits (error flags untouched)
//   consume        : take one credit
//   ret, ret_value : return ret_value credits
//   err_clear      : clear sticky error flags
//   count          : registered count
//   avail/full/low : decodes of the registered count
//   err_underflow/err_overflow : sticky error flags
module vc_ResetReg #(
   parameter int                 p_nbits       = 1,
   parameter logic [p_nbits-1:0] p_reset_value = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [p_nbits-1:0] d,
   output logic [p_nbits-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)
         q <= p_reset_value;
      else
         q <= d;
   end
endmodule

module vc_credit_counter_chan
   import vc_multi_credit_counter_pkg::*;
#(
   parameter int p_count_nbits  = 4,
   parameter int p_max_credits  = 8,
   parameter int p_init_credits = 8,
   parameter int p_low_thresh   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     consume,
   input  logic                     ret,
   input  logic [p_count_nbits-1:0] ret_value,
   input  logic                     err_clear,
   output logic [p_count_nbits-1:0] count,
   output logic                     avail,
   output logic                     full,
   output logic                     low,
   output logic                     err_underflow,
   output logic                     err_overflow
);
   // Two extra bits: one for the carry of count + ret_value, one for sign.
   localparam int NW = p_count_nbits + 2;
   localparam logic [p_count_nbits-1:0] MAX_C  = p_count_nbits'(p_max_credits);
   localparam logic [p_count_nbits-1:0] INIT_C = p_count_nbits'(p_init_credits);

   logic [p_count_nbits-1:0] count_q, count_d;
   logic [1:0]               err_q, err_d;   // {overflow, underflow}
   logic signed [NW-1:0]     cnt_s, ret_s, con_s, net;
   cr_outcome_e              outcome;

   always_comb begin
      cnt_s   = signed'({2'b00, count_q});
      ret_s   = ret ? signed'({2'b00, ret_value}) : '0;
      con_s   = consume ? NW'(1) : '0;
      net     = cnt_s + ret_s - con_s;
      outcome = cr_classify(int'(net), p_max_credits);

      case (outcome)
         CR_UNDER: count_d = '0;
         CR_OVER:  count_d = MAX_C;
         default:  count_d = net[p_count_nbits-1:0];
      endcase
      if (clear)
         count_d = INIT_C;

      // err_clear drops the flags first so that a same-cycle error still lands.
      err_d = err_clear ? 2'b00 : err_q;
      if (!clear) begin
         if (outcome == CR_UNDER) err_d[0] = 1'b1;
         if (outcome == CR_OVER)  err_d[1] = 1'b1;
      end
   end

   vc_ResetReg #(.p_nbits(p_count_nbits), .p_reset_value(INIT_C)) u_count_reg (
      .clk   (clk),
      .reset (reset),
      .d     (count_d),
      .q     (count_q)
   );

   vc_ResetReg #(.p_nbits(2), .p_reset_value(2'b00)) u_err_reg (
      .clk   (clk),
      .reset (reset),
      .d     (err_d),
      .q     (err_q)
   );

   assign count         = count_q;
   assign avail         = (count_q != '0);
   assign full          = (count_q == MAX_C);
   assign low           = (int'(count_q) <= p_low_thresh);
   assign err_underflow = err_q[0];
   assign err_overflow  = err_q[1];
endmodule

// File: rtl/vc_multi_credit_counter.sv
// Bank of independent saturating credit counters, one per channel.
//   clk, reset     : clock / sync active-high reset
//   clear          : reload all channels with p_init_credits
//   consume, ret   : per-channel take-one / return-valid
//   ret_value      : per-channel returned credits, packed p_count_nbits per channel
//   err_clear      : clear all sticky error flags
//   count          : per-channel registered counts, packed like ret_value
//   avail/full/low : per-channel decodes of count
//   any_avail      : OR of avail
//   err_underflow, err_overflow : per-channel sticky error flags
module vc_multi_credit_counter
   import vc_multi_credit_counter_pkg::*;
#(
   parameter int p_nchans       = 4,
   parameter int p_count_nbits  = 4,
   parameter int p_max_credits  = 8,
   parameter int p_init_credits = 8,
   parameter int p_low_thresh   = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear,
   input  logic [p_nchans-1:0]               consume,
   input  logic [p_nchans-1:0]               ret,
   input  logic [p_nchans*p_count_nbits-1:0] ret_value,
   input  logic                              err_clear,
   output logic [p_nchans*p_count_nbits-1:0] count,
   output logic [p_nchans-1:0]               avail,
   output logic [p_nchans-1:0]               full,
   output logic [p_nchans-1:0]               low,
   output logic                              any_avail,
   output logic [p_nchans-1:0]               err_underflow,
   output logic [p_nchans-1:0]               err_overflow
);
   if (!cr_params_ok(p_nchans, p_count_nbits, p_max_credits, p_init_credits)) begin : g_bad_params
      $error("vc_multi_credit_counter: illegal parameter combination");
   end

   for (genvar i = 0; i < p_nchans; i++) begin : g_chan
      vc_credit_counter_chan #(
         .p_count_nbits  (p_count_nbits),
         .p_max_credits  (p_max_credits),
         .p_init_credits (p_init_credits),
         .p_low_thresh   (p_low_thresh)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .clear         (clear),
         .consume       (consume[i]),
         .ret           (ret[i]),
         .ret_value     (ret_value[i*p_count_nbits +: p_count_nbits]),
         .err_clear     (err_clear),
         .count         (count[i*p_count_nbits +: p_count_nbits]),
         .avail         (avail[i]),
         .full          (full[i]),
         .low           (low[i]),
         .err_underflow (err_underflow[i]),
         .err_overflow  (err_overflow[i])
      );
   end

   assign any_avail = |avail;
endmodule

// File: tb/tb_vc_multi_credit_counter.sv
module tb_vc_multi_credit_counter;
   localparam int NC = 4;
   localparam int NB = 4;
   localparam int MAXC = 8;
   localparam int INITC = 8;
   localparam int LOWT = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            clear = 1'b0;
   logic [NC-1:0]   consume = '0;
   logic [NC-1:0]   ret = '0;
   logic [NC*NB-1:0] ret_value = '0;
   logic            err_clear = 1'b0;
   logic [NC*NB-1:0] count;
   logic [NC-1:0]   avail, full, low, err_underflow, err_overflow;
   logic            any_avail;

   int errors = 0;
   int checks = 0;

   // Reference state used by the random regression.
   int m_cnt[NC];
   bit m_uf[NC];
   bit m_of[NC];

   vc_multi_credit_counter #(
      .p_nchans(NC), .p_count_nbits(NB), .p_max_credits(MAXC),
      .p_init_credits(INITC), .p_low_thresh(LOWT)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .consume(consume), .ret(ret),
      .ret_value(ret_value), .err_clear(err_clear), .count(count), .avail(avail),
      .full(full), .low(low), .any_avail(any_avail),
      .err_underflow(err_underflow), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int cnt_of(input int ch);
      logic [NB-1:0] v;
      v = count[ch*NB +: NB];
      return int'(v);
   endfunction

   task automatic idle();
      clear = 0; err_clear = 0; consume = '0; ret = '0; ret_value = '0; reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      tick(); tick();
      idle();
      for (int i = 0; i < NC; i++) begin
         checks++;
         if (cnt_of(i) !== 8) begin
            errors++; $display("FAIL reset_count ch%0d: got %0d want 8", i, cnt_of(i));
         end
      end
      checks++;
      if ({avail, full, low, any_avail} !== {4'b1111, 4'b1111, 4'b0000, 1'b1}) begin
         errors++; $display("FAIL reset_decode: avail=%b full=%b low=%b any=%b", avail, full, low, any_avail);
      end
      checks++;
      if ({err_underflow, err_overflow} !== 8'h00) begin
         errors++; $display("FAIL reset_err: uf=%b of=%b want 0", err_underflow, err_overflow);
      end
   endtask

   task automatic test_drain_underflow();
      int exp;
      for (int k = 1; k <= 9; k++) begin
         consume = 4'b0001;
         tick();
         exp = (8 - k < 0) ? 0 : 8 - k;
         checks++;
         if (cnt_of(0) !== exp || low[0] !== (exp <= 2) || avail[0] !== (exp != 0)) begin
            errors++;
            $display("FAIL drain step%0d: count=%0d low=%b avail=%b want count=%0d", k, cnt_of(0), low[0], avail[0], exp);
         end
         checks++;
         if (err_underflow[0] !== (k == 9)) begin
            errors++; $display("FAIL drain_uf step%0d: got %b want %b", k, err_underflow[0], (k == 9));
         end
      end
      idle();
      checks++;
      if (cnt_of(1) !== 8 || cnt_of(2) !== 8 || cnt_of(3) !== 8 || any_avail !== 1'b1) begin
         errors++; $display("FAIL drain_others: count=%h any=%b", count, any_avail);
      end
   endtask

   task automatic test_covered_consume();
      for (int k = 0; k < 8; k++) begin
         consume = 4'b0010; tick();
      end
      idle();
      checks++;
      if (cnt_of(1) !== 0 || err_underflow[1] !== 1'b0) begin
         errors++; $display("FAIL covered_setup: count=%0d uf=%b want 0/0", cnt_of(1), err_underflow[1]);
      end
      consume = 4'b0010; ret = 4'b0010; ret_value[1*NB +: NB] = 4'd3;
      tick();
      idle();
      checks++;
      if (cnt_of(1) !== 2 || err_underflow[1] !== 1'b0) begin
         errors++; $display("FAIL covered: count=%0d uf=%b want 2/0", cnt_of(1), err_underflow[1]);
      end
      checks++;
      if (any_avail !== 1'b1) begin
         errors++; $display("FAIL any_avail: got %b want 1", any_avail);
      end
   endtask

   task automatic test_overflow();
      consume = 4'b0100; tick(); tick();
      idle();
      ret = 4'b0100; ret_value[2*NB +: NB] = 4'd5;
      tick();
      idle();
      checks++;
      if (cnt_of(2) !== 8 || full[2] !== 1'b1 || err_overflow[2] !== 1'b1) begin
         errors++; $display("FAIL overflow: count=%0d full=%b of=%b want 8/1/1", cnt_of(2), full[2], err_overflow[2]);
      end
      err_clear = 1; tick(); idle();
      checks++;
      if (err_overflow[2] !== 1'b0 || err_underflow !== 4'b0000) begin
         errors++; $display("FAIL err_clear: of=%b uf=%b want 0", err_overflow[2], err_underflow);
      end
      err_clear = 1; ret = 4'b0100; ret_value[2*NB +: NB] = 4'd1;
      tick(); idle();
      checks++;
      if (err_overflow[2] !== 1'b1 || cnt_of(2) !== 8) begin
         errors++; $display("FAIL err_clear_vs_new: of=%b count=%0d want 1/8", err_overflow[2], cnt_of(2));
      end
   endtask

   task automatic test_clear_traffic();
      // state now {ch0=0, ch1=2, ch2=8, ch3=8}; bring to {0,3,5,8} with flags cleared
      ret = 4'b0010; ret_value[1*NB +: NB] = 4'd1; consume = 4'b0100; err_clear = 1;
      tick(); idle();
      consume = 4'b0100; tick(); tick(); idle();
      checks++;
      if (count !== {4'd8, 4'd5, 4'd3, 4'd0} || {err_underflow, err_overflow} !== 8'h00) begin
         errors++; $display("FAIL clear_setup: count=%h uf=%b of=%b", count, err_underflow, err_overflow);
      end
      clear = 1; consume = 4'b1111; ret = 4'b1111; ret_value = 16'hFFFF;
      tick(); idle();
      checks++;
      if (count !== {4'd8, 4'd8, 4'd8, 4'd8} || {err_underflow, err_overflow} !== 8'h00) begin
         errors++; $display("FAIL clear_traffic: count=%h uf=%b of=%b want 8888/0/0", count, err_underflow, err_overflow);
      end
   endtask

   task automatic test_random();
      int net;
      int exp_c;
      for (int i = 0; i < NC; i++) begin m_cnt[i] = INITC; m_uf[i] = 0; m_of[i] = 0; end
      reset = 1; tick(); idle();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         reset     = (cyc == 5000) || ($urandom_range(0, 499) == 0);
         clear     = ($urandom_range(0, 49) == 0);
         err_clear = ($urandom_range(0, 19) == 0);
         consume   = NC'($urandom);
         ret       = NC'($urandom) & NC'($urandom);
         for (int i = 0; i < NC; i++)
            ret_value[i*NB +: NB] = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 15))
                                                                : NB'($urandom_range(0, 2));
         for (int i = 0; i < NC; i++) begin
            if (reset) begin
               m_cnt[i] = INITC; m_uf[i] = 0; m_of[i] = 0;
            end else begin
               if (err_clear) begin m_uf[i] = 0; m_of[i] = 0; end
               if (clear) begin
                  m_cnt[i] = INITC;
               end else begin
                  net = m_cnt[i] + (ret[i] ? int'(ret_value[i*NB +: NB]) : 0) - (consume[i] ? 1 : 0);
                  if (net < 0) begin m_cnt[i] = 0; m_uf[i] = 1; end
                  else if (net > MAXC) begin m_cnt[i] = MAXC; m_of[i] = 1; end
                  else m_cnt[i] = net;
               end
            end
         end
         tick();
         for (int i = 0; i < NC; i++) begin
            exp_c = m_cnt[i];
            checks++;
            if (cnt_of(i) !== exp_c || avail[i] !== (exp_c != 0) || full[i] !== (exp_c == MAXC) ||
                low[i] !== (exp_c <= LOWT) || err_underflow[i] !== m_uf[i] || err_overflow[i] !== m_of[i]) begin
               errors++;
               $display("FAIL random cyc%0d ch%0d: count=%0d av=%b fu=%b lo=%b uf=%b of=%b want count=%0d uf=%b of=%b",
                        cyc, i, cnt_of(i), avail[i], full[i], low[i], err_underflow[i], err_overflow[i],
                        exp_c, m_uf[i], m_of[i]);
            end
         end
         checks++;
         if (any_avail !== ((m_cnt[0] | m_cnt[1] | m_cnt[2] | m_cnt[3]) != 0)) begin
            errors++; $display("FAIL random_any cyc%0d: got %b", cyc, any_avail);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      test_reset();
      test_drain_underflow();
      test_covered_consume();
      test_overflow();
      test_clear_traffic();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
